// File: rtl/ballot_controller_if.sv
// Voting-station signal bundle: operator/button inputs and tally/display outputs.
// The master side drives the buttons and mode; the slave side is the controller.
interface ballot_controller_if;
  logic       mode;
  logic       button1;
  logic       button2;
  logic       button3;
  logic       button4;
  logic       voter_ready;
  logic [3:0] inc_en;
  logic [1:0] disp_sel;
  logic       disp_en;
  logic       ballot_armed;
  logic       vote_done;
  logic       reject;
  logic       timeout;
  logic [7:0] total_votes;

  modport master (
    output mode, button1, button2, button3, button4, voter_ready,
    input  inc_en, disp_sel, disp_en, ballot_armed, vote_done, reject, timeout, total_votes
  );

  modport slave (
    input  mode, button1, button2, button3, button4, voter_ready,
    output inc_en, disp_sel, disp_en, ballot_armed, vote_done, reject, timeout, total_votes
  );
endinterface

// File: rtl/ballot_controller.sv
// Ballot controller: one vote per official unlock, debounced single-button selection.
// Optional armed-ballot expiry is enabled by defining BALLOT_TIMEOUT_EN.
module ballot_controller #(
  parameter int HOLD_CYCLES    = 10,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               rst,
  ballot_controller_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, ARMED, DEBOUNCE, REJECT_WAIT, CAST, RELEASE
  } state_t;

  localparam logic [7:0] hold_lim = 8'(HOLD_CYCLES);

  state_t     state;
  logic [7:0] hold_cnt;
  logic [1:0] idx;
  logic [3:0] inc_en;
  logic [1:0] disp_sel;
  logic       disp_en;
  logic       ballot_armed;
  logic       vote_done;
  logic       reject;
  logic       timeout;
  logic [7:0] total_votes;

  logic [3:0] btn;
  logic       btn_none;
  logic       btn_one;
  logic [1:0] btn_idx;
  logic       same_btn;
  logic       in_armed;
  logic       to_hit;

  assign btn      = {bus.button4, bus.button3, bus.button2, bus.button1};
  assign btn_none = (btn == 4'b0000);
  assign btn_one  = !btn_none && ((btn & (btn - 4'd1)) == 4'b0000);
  assign same_btn = btn_one && (btn_idx == idx);
  assign in_armed = (state == ARMED) || (state == DEBOUNCE) || (state == REJECT_WAIT);

  always_comb begin
    // NOTE: default assignment first so no latch is inferred for unlisted patterns.
    btn_idx = 2'd0;
    case (btn)
      4'b0010: btn_idx = 2'd1;
      4'b0100: btn_idx = 2'd2;
      4'b1000: btn_idx = 2'd3;
      default: btn_idx = 2'd0;
    endcase
  end

`ifdef BALLOT_TIMEOUT_EN
  localparam logic [15:0] to_lim = 16'(TIMEOUT_CYCLES);
  logic [15:0] to_cnt;

  // Runs across ARMED/DEBOUNCE/REJECT_WAIT; every arming passes through IDLE, which zeroes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           to_cnt <= '0;
    else if (in_armed) to_cnt <= to_cnt + 16'd1;
    else               to_cnt <= '0;
  end

  assign to_hit = in_armed && ((to_cnt + 16'd1) == to_lim);
`else
  assign to_hit = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      hold_cnt     <= '0;
      idx          <= '0;
      inc_en       <= '0;
      disp_sel     <= '0;
      disp_en      <= 1'b0;
      ballot_armed <= 1'b0;
      vote_done    <= 1'b0;
      reject       <= 1'b0;
      timeout      <= 1'b0;
      total_votes  <= '0;
    end else begin
      inc_en    <= '0;
      vote_done <= 1'b0;
      reject    <= 1'b0;
      timeout   <= 1'b0;
      disp_en   <= bus.mode;
      if (bus.mode && btn_one) disp_sel <= btn_idx;

      case (state)
        IDLE: begin
          if (bus.voter_ready && !bus.mode) begin
            state        <= ARMED;
            ballot_armed <= 1'b1;
            hold_cnt     <= '0;
          end
        end

        ARMED: begin
          if (bus.mode) begin
            state        <= IDLE;
            ballot_armed <= 1'b0;
          end else if (to_hit) begin
            state        <= IDLE;
            ballot_armed <= 1'b0;
            timeout      <= 1'b1;
          end else if (btn_one) begin
            state    <= DEBOUNCE;
            idx      <= btn_idx;
            hold_cnt <= 8'd1;
          end else if (!btn_none) begin
            state  <= REJECT_WAIT;
            reject <= 1'b1;
          end
        end

        DEBOUNCE: begin
          // A completing hold outranks an expiring ballot in the same cycle.
          if (bus.mode) begin
            state        <= IDLE;
            ballot_armed <= 1'b0;
            hold_cnt     <= '0;
          end else if (same_btn && ((hold_cnt + 8'd1) == hold_lim)) begin
            state        <= CAST;
            ballot_armed <= 1'b0;
            hold_cnt     <= '0;
            inc_en       <= 4'b0001 << idx;
            vote_done    <= 1'b1;
            if (total_votes != 8'hFF) total_votes <= total_votes + 8'd1;
          end else if (to_hit) begin
            state        <= IDLE;
            ballot_armed <= 1'b0;
            hold_cnt     <= '0;
            timeout      <= 1'b1;
          end else if (same_btn) begin
            hold_cnt <= hold_cnt + 8'd1;
          end else if (btn_none || btn_one) begin
            state    <= ARMED;
            hold_cnt <= '0;
          end else begin
            state    <= REJECT_WAIT;
            hold_cnt <= '0;
            reject   <= 1'b1;
          end
        end

        REJECT_WAIT: begin
          if (bus.mode) begin
            state        <= IDLE;
            ballot_armed <= 1'b0;
          end else if (to_hit) begin
            state        <= IDLE;
            ballot_armed <= 1'b0;
            timeout      <= 1'b1;
          end else if (btn_none) begin
            state <= ARMED;
          end
        end

        CAST:    state <= RELEASE;

        // Waiting for a full release keeps a held button from voting twice.
        RELEASE: if (btn_none) state <= IDLE;

        default: begin
          state        <= IDLE;
          ballot_armed <= 1'b0;
        end
      endcase
    end
  end

  assign bus.inc_en       = inc_en;
  assign bus.disp_sel     = disp_sel;
  assign bus.disp_en      = disp_en;
  assign bus.ballot_armed = ballot_armed;
  assign bus.vote_done    = vote_done;
  assign bus.reject       = reject;
  assign bus.timeout      = timeout;
  assign bus.total_votes  = total_votes;

endmodule
